// File: rtl/error_sampler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : error_sampler_pkg                                            |
// | Description : Shared types, defaults and the saturating-subtract helper    |
// |               for the ADC error sampler.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package error_sampler_pkg;

  localparam int ADC_WIDTH_DEF = 13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CALC   = 3'd3,
    ST_STROBE = 3'd4
  } state_e;

  // Unsigned sp - adc, clamped into the signed ADC_WIDTH_DEF range. The
  // difference is formed one bit wider; it fits the narrow signed range only
  // when its two top bits agree, otherwise the sign bit picks the rail.
  function automatic logic [ADC_WIDTH_DEF-1:0] sat_sub(
    input logic [ADC_WIDTH_DEF-1:0] sp,
    input logic [ADC_WIDTH_DEF-1:0] adc
  );
    logic [ADC_WIDTH_DEF:0] diff;
    diff = {1'b0, sp} - {1'b0, adc};
    if (diff[ADC_WIDTH_DEF] != diff[ADC_WIDTH_DEF-1]) begin
      sat_sub = {diff[ADC_WIDTH_DEF], {(ADC_WIDTH_DEF-1){~diff[ADC_WIDTH_DEF]}}};
    end else begin
      sat_sub = diff[ADC_WIDTH_DEF-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/error_sampler_err_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : error_sampler_err_sat                                        |
// | Description : Combinational unsigned subtract with signed saturation.      |
// |               Shared by the sampler and the derivative path.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module error_sampler_err_sat
  import error_sampler_pkg::*;
#(
  parameter int W = ADC_WIDTH_DEF
) (
  input  logic [W-1:0] sp,
  input  logic [W-1:0] adc,
  output logic [W-1:0] err
);

  if (W == ADC_WIDTH_DEF) begin : g_pkg_fn
    // Default width: reuse the package helper so both users agree bit-for-bit.
    assign err = sat_sub(sp, adc);
  end else begin : g_generic
    logic [W:0] w_diff;

    // Same clamp as the package helper, written for an arbitrary width.
    always_comb begin
      w_diff = {1'b0, sp} - {1'b0, adc};
      if (w_diff[W] != w_diff[W-1]) begin
        err = {w_diff[W], {(W-1){~w_diff[W]}}};
      end else begin
        err = w_diff[W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/error_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : error_sampler                                                |
// | Description : Paces ADC conversions, captures results, forms a saturated   |
// |               setpoint error and keeps a cur/old pair with an int_en       |
// |               strobe for the integrator and P/D paths.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module error_sampler
  import error_sampler_pkg::*;
#(
  parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int SAMPLE_DIV = 100,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADC_WIDTH-1:0] setpoint,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [ADC_WIDTH-1:0] cur_error,
  output logic [ADC_WIDTH-1:0] old_error,
  output logic                 int_en,
  output logic                 fault,
  output logic [15:0]          sample_cnt
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

  state_e                 state_q,    state_d;
  logic [DIV_W-1:0]       div_cnt_q,  div_cnt_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [ADC_WIDTH-1:0]   sp_q,       sp_d;
  logic [ADC_WIDTH-1:0]   adc_q,      adc_d;
  logic [ADC_WIDTH-1:0]   cur_q,      cur_d;
  logic [ADC_WIDTH-1:0]   old_q,      old_d;
  logic [15:0]            cnt_q,      cnt_d;
  logic                   primed_q,   primed_d;
  logic                   fault_q,    fault_d;
  logic                   adc_start_q, adc_start_d;
  logic                   int_en_q,   int_en_d;
  logic                   run_q,      run_d;
  logic                   w_div_end;
  logic [ADC_WIDTH-1:0]   w_sat;

  error_sampler_err_sat #(
    .W (ADC_WIDTH)
  ) u_err_sat (
    .sp  (sp_q),
    .adc (adc_q),
    .err (w_sat)
  );

  // Next-state logic: divider, conversion handshake, error pair update.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    sp_d        = sp_q;
    adc_d       = adc_q;
    cur_d       = cur_q;
    old_d       = old_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    fault_d     = fault_q;
    adc_start_d = 1'b0;
    int_en_d    = 1'b0;
    run_d       = run;
    w_div_end   = (div_cnt_q == c_div_last);

    // A fresh run request forgives a previous ADC timeout.
    if (run && !run_q) begin
      fault_d = 1'b0;
    end

    if (!run) begin
      // Abandon any conversion in flight; the next run starts unprimed.
      state_d   = ST_IDLE;
      div_cnt_d = '0;
      primed_d  = 1'b0;
    end else begin
      // The divider keeps running in every state so start spacing is fixed.
      div_cnt_d = w_div_end ? '0 : div_cnt_q + DIV_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (w_div_end) begin
            state_d     = ST_START;
            adc_start_d = 1'b1;
          end
        end
        ST_START: begin
          // Freeze the setpoint so later changes cannot skew this sample.
          sp_d       = setpoint;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          // A done pulse on the final wait cycle still counts as on time.
          if (adc_done) begin
            adc_d   = adc_data;
            state_d = ST_CALC;
          end else if (wait_cnt_q == c_wait_last) begin
            fault_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_CALC: begin
          // The first sample after run seeds both halves of the pair.
          old_d    = primed_q ? cur_q : w_sat;
          cur_d    = w_sat;
          primed_d = 1'b1;
          cnt_d    = cnt_q + 16'd1;
          int_en_d = primed_q;
          state_d  = ST_STROBE;
        end
        ST_STROBE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      sp_q        <= '0;
      adc_q       <= '0;
      cur_q       <= '0;
      old_q       <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      fault_q     <= 1'b0;
      adc_start_q <= 1'b0;
      int_en_q    <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      sp_q        <= sp_d;
      adc_q       <= adc_d;
      cur_q       <= cur_d;
      old_q       <= old_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      fault_q     <= fault_d;
      adc_start_q <= adc_start_d;
      int_en_q    <= int_en_d;
      run_q       <= run_d;
    end
  end

  assign adc_start  = adc_start_q;
  assign int_en     = int_en_q;
  assign cur_error  = cur_q;
  assign old_error  = old_q;
  assign fault      = fault_q;
  assign sample_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_error_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_error_sampler                                             |
// | Description : Self-checking bench for error_sampler with an ADC model and  |
// |               an arithmetic reference for the error pair.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_error_sampler;

  localparam int W   = 13;
  localparam int DIV = 100;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic [W-1:0] setpoint;
  logic         adc_start;
  logic         adc_done;
  logic [W-1:0] adc_data;
  logic [W-1:0] cur_error;
  logic [W-1:0] old_error;
  logic         int_en;
  logic         fault;
  logic [15:0]  sample_cnt;

  error_sampler #(
    .ADC_WIDTH  (W),
    .SAMPLE_DIV (DIV),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .setpoint   (setpoint),
    .adc_start  (adc_start),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .cur_error  (cur_error),
    .old_error  (old_error),
    .int_en     (int_en),
    .fault      (fault),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  // Reference state: error pair, priming, sample count, sticky fault.
  logic [W-1:0] cur_m, old_m;
  logic         primed_m;
  int           cnt_m;
  logic         fault_m;
  int           last_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed difference clamped to the W-bit two's complement range.
  function automatic logic [W-1:0] sat_ref(input int sp, input int ad);
    int d;
    d = sp - ad;
    if (d > (1 << (W-1)) - 1) d = (1 << (W-1)) - 1;
    if (d < -(1 << (W-1)))    d = -(1 << (W-1));
    return d[W-1:0];
  endfunction

  task automatic model_reset();
    cur_m = '0; old_m = '0; primed_m = 1'b0; cnt_m = 0; fault_m = 1'b0;
    last_start = -1;
  endtask

  // Wait (bounded) for a conversion request, check spacing, present setpoint.
  task automatic wait_start(input logic [W-1:0] sp);
    int n = 0;
    while (adc_start !== 1'b1 && n < 3*DIV) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {31'd0, adc_start}, 32'd1);
    if (last_start >= 0) chk("period", cyc - last_start, DIV);
    last_start = cyc;
    setpoint   = sp;
  endtask

  // One full conversion answered d cycles into WAIT.
  task automatic do_sample(input logic [W-1:0] sp, input logic [W-1:0] data, input int d);
    logic [W-1:0] e;
    logic         exp_int;
    wait_start(sp);
    @(negedge clk);
    setpoint = W'($urandom);
    repeat (d) @(negedge clk);
    adc_done = 1'b1;
    adc_data = data;
    @(negedge clk);
    adc_done = 1'b0;
    adc_data = W'($urandom);
    e       = sat_ref(int'(sp), int'(data));
    exp_int = primed_m;
    old_m   = primed_m ? cur_m : e;
    cur_m   = e;
    primed_m = 1'b1;
    cnt_m   = (cnt_m + 1) % 65536;
    @(negedge clk);
    chk("int_en", {31'd0, int_en}, {31'd0, exp_int});
    chk("cur_error", {19'd0, cur_error}, {19'd0, cur_m});
    chk("old_error", {19'd0, old_error}, {19'd0, old_m});
    chk("sample_cnt", {16'd0, sample_cnt}, cnt_m);
    chk("fault", {31'd0, fault}, {31'd0, fault_m});
    @(negedge clk);
    chk("int_en_one_cycle", {31'd0, int_en}, 32'd0);
  endtask

  // adc_done while idle must be ignored.
  task automatic stray();
    adc_done = 1'b1;
    adc_data = W'($urandom);
    @(negedge clk);
    adc_done = 1'b0;
  endtask

  task automatic do_timeout();
    wait_start(W'($urandom));
    @(negedge clk);
    repeat (TO-1) @(negedge clk);
    chk("fault_before_timeout", {31'd0, fault}, 32'd0);
    @(negedge clk);
    chk("fault_at_timeout", {31'd0, fault}, 32'd1);
    chk("no_int_en_timeout", {31'd0, int_en}, 32'd0);
    fault_m = 1'b1;
  endtask

  task automatic toggle_run();
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    fault_m    = 1'b0;
    primed_m   = 1'b0;
    last_start = -1;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
  endtask

  task automatic drop_in_wait();
    wait_start(W'($urandom));
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    stray();
    repeat (3) begin
      @(negedge clk);
      chk("no_int_en_after_drop", {31'd0, int_en}, 32'd0);
    end
    chk("cur_hold", {19'd0, cur_error}, {19'd0, cur_m});
    chk("old_hold", {19'd0, old_error}, {19'd0, old_m});
    chk("cnt_hold", {16'd0, sample_cnt}, cnt_m);
    run        = 1'b1;
    primed_m   = 1'b0;
    fault_m    = 1'b0;
    last_start = -1;
  endtask

  task automatic reset_mid_calc();
    wait_start(W'($urandom));
    @(negedge clk);
    repeat (3) @(negedge clk);
    adc_done = 1'b1;
    adc_data = W'($urandom);
    @(negedge clk);
    adc_done = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("rst_adc_start", {31'd0, adc_start}, 32'd0);
    chk("rst_int_en", {31'd0, int_en}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_cur", {19'd0, cur_error}, 32'd0);
    chk("rst_old", {19'd0, old_error}, 32'd0);
    chk("rst_cnt", {16'd0, sample_cnt}, 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; setpoint = '0; adc_done = 1'b0; adc_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_adc_start", {31'd0, adc_start}, 32'd0);
    chk("reset_int_en", {31'd0, int_en}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    chk("reset_cur", {19'd0, cur_error}, 32'd0);
    chk("reset_old", {19'd0, old_error}, 32'd0);
    chk("reset_cnt", {16'd0, sample_cnt}, 32'd0);
    rst = 1'b0;
    run = 1'b1;

    // Priming then first strobed pair.
    do_sample(W'(200), W'(100), 5);
    do_sample(W'(200), W'(0), 10);
    // Saturation rails and in-range values; done on the last wait cycle.
    do_sample(W'(0), W'(8191), 3);
    do_sample(W'(8191), W'(0), 0);
    do_sample(W'(100), W'(5000), TO-1);
    do_sample(W'(4000), W'(100), 1);
    do_sample(W'(4095), W'(0), 2);
    do_sample(W'(0), W'(4096), 2);

    // Timeout, sticky fault, pacing continues, run toggle clears it.
    do_timeout();
    do_sample(W'($urandom), W'($urandom), 4);
    toggle_run();
    do_sample(W'($urandom), W'($urandom), 6);

    // Run dropped mid-conversion, then re-prime.
    drop_in_wait();
    do_sample(W'($urandom), W'($urandom), 2);
    do_sample(W'($urandom), W'($urandom), 7);

    // Randomized samples with stray done pulses while idle.
    for (int i = 0; i < 8; i++) begin
      do_sample(W'($urandom), W'($urandom), int'($urandom_range(0, TO-1)));
      if (i % 3 == 0) stray();
    end

    // Reset during CALC, then ten paced samples.
    reset_mid_calc();
    for (int i = 0; i < 10; i++) begin
      do_sample(W'($urandom), W'($urandom), int'($urandom_range(0, TO-1)));
    end
    chk("sample_cnt_ten", {16'd0, sample_cnt}, 32'd10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
